// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: segment bit positions and hex glyph table.
package seg_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    typedef logic [SEG_G:SEG_A] seg_t;

    // Entry n holds the active-high g..a pattern for hex digit n
    localparam seg_t [15:0] HEX_SEG_TBL = {
        7'h71, 7'h79, 7'h5E, 7'h39,
        7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66,
        7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic seg_t hex_to_seg(input logic [3:0] nib);
        return HEX_SEG_TBL[nib];
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-high seven-segment pattern.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] i_nib,
    output seg_t       o_seg
);

    assign o_seg = hex_to_seg(i_nib);

endmodule

// File: rtl/seg_mux_driver.sv
// Time-multiplexed NUM_DIGITS seven-segment driver with frame-synchronous load.
// Optional leading-zero suppression when SEG_LEADING_ZERO_BLANK_EN is defined.
module seg_mux_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS      = 4,
    parameter int REFRESH_DIV     = 16000,
    parameter int GUARD_CYC       = 2,
    parameter int SEG_ACTIVE_HIGH = 1,
    parameter int DIG_ACTIVE_HIGH = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic                    load,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   dig_en,
    output logic                    frame_done
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    localparam logic SEG_INV = (SEG_ACTIVE_HIGH == 0);
    localparam logic DIG_INV = (DIG_ACTIVE_HIGH == 0);

    logic [PW-1:0]             r_presc;
    logic [IW-1:0]             r_idx;

    logic [4*NUM_DIGITS-1:0]   r_pend_data;
    logic [NUM_DIGITS-1:0]     r_pend_dp;
    logic [NUM_DIGITS-1:0]     r_pend_blank;
    logic [4*NUM_DIGITS-1:0]   r_disp_data;
    logic [NUM_DIGITS-1:0]     r_disp_dp;
    logic [NUM_DIGITS-1:0]     r_disp_blank;

    logic [6:0]                r_seg;
    logic                      r_dp;
    logic [NUM_DIGITS-1:0]     r_dig;
    logic                      r_frame;

    logic                      w_tick;
    logic                      w_frame;
    logic                      w_guard;
    logic [NUM_DIGITS-1:0]     w_lz;
    logic [3:0]                w_nib;
    logic                      w_dp_bit;
    logic                      w_dark;
    logic [NUM_DIGITS-1:0]     w_sel;
    seg_t                      w_seg_raw;
    logic [6:0]                w_seg_on;
    logic                      w_dp_on;
    logic [NUM_DIGITS-1:0]     w_dig_on;

    assign w_tick  = (r_presc == PRE_LAST);
    assign w_frame = w_tick && (r_idx == IDX_LAST);

    generate
        if (GUARD_CYC > 0) begin : g_guard
            assign w_guard = (r_presc < PW'(GUARD_CYC));
        end else begin : g_noguard
            assign w_guard = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
            r_idx   <= w_frame ? '0 : r_idx + IW'(1);
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    // A load landing on the frame edge goes straight to the display shadow
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pend_data  <= '0;
            r_pend_dp    <= '0;
            r_pend_blank <= '1;
            r_disp_data  <= '0;
            r_disp_dp    <= '0;
            r_disp_blank <= '1;
        end else begin
            if (load) begin
                r_pend_data  <= data;
                r_pend_dp    <= dp_in;
                r_pend_blank <= blank;
            end
            if (w_frame) begin
                r_disp_data  <= load ? data  : r_pend_data;
                r_disp_dp    <= load ? dp_in : r_pend_dp;
                r_disp_blank <= load ? blank : r_pend_blank;
            end
        end
    end

`ifdef SEG_LEADING_ZERO_BLANK_EN
    logic w_lead;

    // Walk down from the top digit while digits are zero with no dp
    always_comb begin
        w_lz   = '0;
        w_lead = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            w_lead = w_lead
                && (r_disp_data[4*i +: 4] == 4'h0)
                && !r_disp_dp[i];
            w_lz[i] = w_lead;
        end
    end
`else
    assign w_lz = '0;
`endif

    always_comb begin
        w_nib    = '0;
        w_dp_bit = 1'b0;
        w_dark   = 1'b0;
        w_sel    = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == IW'(i)) begin
                w_nib    = r_disp_data[4*i +: 4];
                w_dp_bit = r_disp_dp[i];
                w_dark   = r_disp_blank[i] | w_lz[i];
                w_sel[i] = 1'b1;
            end
        end
    end

    seg_hex_decode u_dec (
        .i_nib (w_nib),
        .o_seg (w_seg_raw)
    );

    assign w_seg_on = (w_guard || w_dark) ? 7'h00 : w_seg_raw;
    assign w_dp_on  = !w_guard && !w_dark && w_dp_bit;
    assign w_dig_on = w_guard ? '0 : w_sel;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_seg   <= {7{SEG_INV}};
            r_dp    <= SEG_INV;
            r_dig   <= {NUM_DIGITS{DIG_INV}};
            r_frame <= 1'b0;
        end else begin
            r_seg   <= w_seg_on ^ {7{SEG_INV}};
            r_dp    <= w_dp_on ^ SEG_INV;
            r_dig   <= w_dig_on ^ {NUM_DIGITS{DIG_INV}};
            r_frame <= w_frame;
        end
    end

    assign seg        = r_seg;
    assign dp         = r_dp;
    assign dig_en     = r_dig;
    assign frame_done = r_frame;

endmodule

// File: tb/tb_seg_mux_driver.sv
// Self-checking bench for seg_mux_driver against a cycle-count reference model.
// Leading-zero expectations follow SEG_LEADING_ZERO_BLANK_EN.
module tb_seg_mux_driver;

    localparam int ND = 4;
    localparam int RD = 8;
    localparam int GC = 1;
    localparam int FR = ND * RD;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic [15:0] data   = '0;
    logic [3:0]  dp_in  = '0;
    logic [3:0]  blank  = '0;
    logic        load   = 1'b0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  dig_en;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    int          m_n = 0;
    logic [15:0] p_data, d_data;
    logic [3:0]  p_dp, d_dp, p_bl, d_bl;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic [3:0]  e_dig;
    logic        e_fd;

    always #5 clk = ~clk;

    seg_mux_driver #(
        .NUM_DIGITS      (ND),
        .REFRESH_DIV     (RD),
        .GUARD_CYC       (GC),
        .SEG_ACTIVE_HIGH (1),
        .DIG_ACTIVE_HIGH (0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data       (data),
        .dp_in      (dp_in),
        .blank      (blank),
        .load       (load),
        .seg        (seg),
        .dp         (dp),
        .dig_en     (dig_en),
        .frame_done (frame_done)
    );

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'h0: return 7'h3F;  4'h1: return 7'h06;
            4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;
            4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;
            4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;
            4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    function automatic int dig_of(input logic [3:0] en);
        case (en)
            4'hE: return 0;
            4'hD: return 1;
            4'hB: return 2;
            4'h7: return 3;
            default: return -1;
        endcase
    endfunction

    // Model: state after n edges is slot n/RD, offset n%RD; outputs lag one cycle
    task automatic cyc();
        int  p;
        int  ix;
        bit  dark;
        @(posedge clk);
        if (!rst_n) begin
            m_n = 0;
            p_data = '0; d_data = '0;
            p_dp = '0; d_dp = '0;
            p_bl = '1; d_bl = '1;
            e_seg = '0; e_dp = 1'b0; e_dig = 4'hF; e_fd = 1'b0;
        end else begin
            p  = m_n % RD;
            ix = (m_n / RD) % ND;
            e_fd = ((m_n % FR) == FR - 1);
            dark = d_bl[ix];
`ifdef SEG_LEADING_ZERO_BLANK_EN
            begin
                int msd;
                msd = 0;
                for (int i = 0; i < ND; i++)
                    if (d_data[4*i +: 4] != 4'h0 || d_dp[i]) msd = i;
                if (ix > msd) dark = 1'b1;
            end
`endif
            if (p < GC) begin
                e_seg = '0; e_dp = 1'b0; e_dig = 4'hF;
            end else begin
                e_dig = ~(4'b0001 << ix);
                e_seg = dark ? 7'h00 : glyph(d_data[4*ix +: 4]);
                e_dp  = dark ? 1'b0 : d_dp[ix];
            end
            if (load) begin
                p_data = data; p_dp = dp_in; p_bl = blank;
            end
            if (e_fd) begin
                d_data = p_data; d_dp = p_dp; d_bl = p_bl;
            end
            m_n++;
        end
        #1;
    endtask

    task automatic goto_pos(input int pos);
        for (int k = 0; k < FR && (m_n % FR) != pos; k++) cyc();
    endtask

    task automatic test_reset();
        int first_fd;
        int second_fd;
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            checks++;
            if ({seg, dp, dig_en, frame_done} !== {7'h00, 1'b0, 4'hF, 1'b0}) begin
                errors++;
                $display("FAIL reset_state got=%h required=%h",
                    {seg, dp, dig_en, frame_done}, {7'h00, 1'b0, 4'hF, 1'b0});
            end
        end
        rst_n = 1'b1;
        first_fd = -1;
        second_fd = -1;
        for (int k = 1; k <= 80; k++) begin
            cyc();
            checks++;
            if ({seg, dp, dig_en, frame_done} !== {e_seg, e_dp, e_dig, e_fd}) begin
                errors++;
                $display("FAIL idle_scan n=%0d got=%h required=%h", m_n,
                    {seg, dp, dig_en, frame_done}, {e_seg, e_dp, e_dig, e_fd});
            end
            if (frame_done === 1'b1) begin
                if (first_fd < 0) first_fd = k;
                else if (second_fd < 0) second_fd = k;
            end
        end
        checks++;
        if (first_fd != 32 || second_fd != 64) begin
            errors++;
            $display("FAIL frame_done_timing got=%0d,%0d required=32,64",
                first_fd, second_fd);
        end
    endtask

    task automatic test_midframe_load();
        int hit[ND];
        logic [6:0] want[ND];
        want[0] = 7'h71; want[1] = 7'h77; want[2] = 7'h5B; want[3] = 7'h06;
        for (int i = 0; i < ND; i++) hit[i] = 0;
        goto_pos(10);
        data = 16'h12AF; dp_in = 4'h0; blank = 4'h0; load = 1'b1;
        cyc();
        load = 1'b0;
        for (int k = 0; k < FR && (m_n % FR) != 0; k++) begin
            checks++;
            if ({seg, dp, dig_en, frame_done} !== {e_seg, e_dp, e_dig, e_fd}) begin
                errors++;
                $display("FAIL midframe_old n=%0d got=%h required=%h", m_n,
                    {seg, dp, dig_en, frame_done}, {e_seg, e_dp, e_dig, e_fd});
            end
            cyc();
        end
        for (int k = 0; k < FR; k++) begin
            cyc();
            checks++;
            if ({seg, dp, dig_en, frame_done} !== {e_seg, e_dp, e_dig, e_fd}) begin
                errors++;
                $display("FAIL midframe_new n=%0d got=%h required=%h", m_n,
                    {seg, dp, dig_en, frame_done}, {e_seg, e_dp, e_dig, e_fd});
            end
            if (dig_of(dig_en) >= 0 && seg == want[dig_of(dig_en)])
                hit[dig_of(dig_en)]++;
        end
        for (int i = 0; i < ND; i++) begin
            checks++;
            if (hit[i] != RD - GC) begin
                errors++;
                $display("FAIL midframe_slot%0d active=%0d required=%0d",
                    i, hit[i], RD - GC);
            end
        end
    endtask

    task automatic test_two_loads();
        int hit;
        hit = 0;
        goto_pos(5);
        data = 16'h1111; blank = 4'h0; dp_in = 4'h0; load = 1'b1;
        cyc();
        load = 1'b0;
        goto_pos(20);
        data = 16'h2222; load = 1'b1;
        cyc();
        load = 1'b0;
        for (int k = 0; k < FR && (m_n % FR) != 0; k++) cyc();
        for (int k = 0; k < FR; k++) begin
            cyc();
            checks++;
            if ({seg, dp, dig_en, frame_done} !== {e_seg, e_dp, e_dig, e_fd}) begin
                errors++;
                $display("FAIL two_loads n=%0d got=%h required=%h", m_n,
                    {seg, dp, dig_en, frame_done}, {e_seg, e_dp, e_dig, e_fd});
            end
            if (dig_en != 4'hF && seg == 7'h5B) hit++;
        end
        checks++;
        if (hit != ND * (RD - GC)) begin
            errors++;
            $display("FAIL two_loads_last_wins lit=%0d required=%0d",
                hit, ND * (RD - GC));
        end
    endtask

    task automatic test_bypass();
        int hit;
        hit = 0;
        goto_pos(FR - 1);
        data = 16'h0008; dp_in = 4'b0010; blank = 4'h0; load = 1'b1;
        cyc();
        load = 1'b0;
        for (int k = 0; k < FR; k++) begin
            cyc();
            checks++;
            if ({seg, dp, dig_en, frame_done} !== {e_seg, e_dp, e_dig, e_fd}) begin
                errors++;
                $display("FAIL bypass n=%0d got=%h required=%h", m_n,
                    {seg, dp, dig_en, frame_done}, {e_seg, e_dp, e_dig, e_fd});
            end
            if (dig_en == 4'hD && seg == 7'h3F && dp == 1'b1) hit++;
        end
        checks++;
        if (hit != RD - GC) begin
            errors++;
            $display("FAIL bypass_digit1 active=%0d required=%0d", hit, RD - GC);
        end
    endtask

    task automatic test_reset_mid();
        int lit;
        lit = 0;
        goto_pos(2 * RD + 4);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        checks++;
        if ({seg, dp, dig_en, frame_done} !== {7'h00, 1'b0, 4'hF, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid got=%h required=%h",
                {seg, dp, dig_en, frame_done}, {7'h00, 1'b0, 4'hF, 1'b0});
        end
        for (int k = 0; k < 2 * FR; k++) begin
            cyc();
            checks++;
            if ({seg, dp, dig_en, frame_done} !== {e_seg, e_dp, e_dig, e_fd}) begin
                errors++;
                $display("FAIL after_reset n=%0d got=%h required=%h", m_n,
                    {seg, dp, dig_en, frame_done}, {e_seg, e_dp, e_dig, e_fd});
            end
            if (seg != 7'h00 || dp != 1'b0) lit++;
        end
        checks++;
        if (lit != 0) begin
            errors++;
            $display("FAIL reset_blanks_shadow lit=%0d required=0", lit);
        end
    endtask

    task automatic test_lzb(input logic [15:0] val, input int want_lit);
        int lit;
        lit = 0;
        goto_pos(3);
        data = val; dp_in = 4'h0; blank = 4'h0; load = 1'b1;
        cyc();
        load = 1'b0;
        for (int k = 0; k < FR && (m_n % FR) != 0; k++) cyc();
        for (int k = 0; k < FR; k++) begin
            cyc();
            checks++;
            if ({seg, dp, dig_en, frame_done} !== {e_seg, e_dp, e_dig, e_fd}) begin
                errors++;
                $display("FAIL lzb n=%0d got=%h required=%h", m_n,
                    {seg, dp, dig_en, frame_done}, {e_seg, e_dp, e_dig, e_fd});
            end
            if (dig_en != 4'hF && seg != 7'h00) lit++;
        end
        checks++;
        if (lit != want_lit * (RD - GC)) begin
            errors++;
            $display("FAIL lzb_%h lit=%0d required=%0d", val, lit,
                want_lit * (RD - GC));
        end
    endtask

    task automatic test_random();
        int span;
        for (int it = 0; it < 12; it++) begin
            goto_pos(int'($urandom_range(0, FR - 1)));
            data  = 16'($urandom);
            dp_in = 4'($urandom);
            blank = 4'($urandom) & 4'($urandom);
            load  = 1'b1;
            cyc();
            load  = 1'b0;
            span = int'($urandom_range(1, 2 * FR));
            for (int k = 0; k < span; k++) begin
                checks++;
                if ({seg, dp, dig_en, frame_done} !== {e_seg, e_dp, e_dig, e_fd}) begin
                    errors++;
                    $display("FAIL random it=%0d n=%0d got=%h required=%h",
                        it, m_n, {seg, dp, dig_en, frame_done},
                        {e_seg, e_dp, e_dig, e_fd});
                end
                cyc();
            end
        end
    endtask

    initial begin
        test_reset();
        test_midframe_load();
        test_two_loads();
        test_bypass();
        test_reset_mid();
`ifdef SEG_LEADING_ZERO_BLANK_EN
        test_lzb(16'h0050, 2);
        test_lzb(16'h0000, 1);
`else
        test_lzb(16'h0050, 4);
        test_lzb(16'h0000, 4);
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
